// File: rtl/alu_issue_queue_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_issue_queue_if : producer, ALU and consumer signals of the    |
// | ALU issue queue. Revision 1.0                                     |
// +------------------------------------------------------------------+
interface alu_issue_queue_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Producer side
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_f;

  // ALU side
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_f;
  logic [WIDTH-1:0] alu_y;
  logic             alu_zf;
  logic             alu_of;
  logic             alu_cf;

  // Consumer side
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic [2:0]       out_f;
  logic             out_zf;
  logic             out_of;
  logic             out_cf;

  // Status
  logic [CNT_W-1:0] count;
  logic             sticky_clr;
  logic [2:0]       sticky_flags;

  modport slave (
    input  in_valid, in_a, in_b, in_f,
    output in_ready,
    output alu_a, alu_b, alu_f,
    input  alu_y, alu_zf, alu_of, alu_cf,
    output out_valid, out_y, out_f, out_zf, out_of, out_cf,
    input  out_ready,
    output count,
    input  sticky_clr,
    output sticky_flags
  );

  modport master (
    output in_valid, in_a, in_b, in_f,
    input  in_ready,
    input  alu_a, alu_b, alu_f,
    output alu_y, alu_zf, alu_of, alu_cf,
    input  out_valid, out_y, out_f, out_zf, out_of, out_cf,
    output out_ready,
    input  count,
    output sticky_clr,
    input  sticky_flags
  );
endinterface
`default_nettype wire

// File: rtl/alu_issue_queue.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_issue_queue : op FIFO feeding a combinational ALU, plus a      |
// | one-entry result slot. Option macro: ALU_ISSUE_STICKY_EN. Rev 1.0 |
// +------------------------------------------------------------------+
module alu_issue_queue #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  alu_issue_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] c_count_full = CNT_W'(DEPTH);

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } slot_state_t;

  logic [WIDTH-1:0] r_mem_a [DEPTH];
  logic [WIDTH-1:0] r_mem_b [DEPTH];
  logic [2:0]       r_mem_f [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  slot_state_t      r_state;
  logic [WIDTH-1:0] r_out_y;
  logic [2:0]       r_out_f;
  logic             r_out_zf;
  logic             r_out_of;
  logic             r_out_cf;

  logic             w_not_empty;
  logic             w_in_ready;
  logic             w_push;
  logic             w_slot_free;
  logic             w_issue;
  logic [WIDTH-1:0] w_head_a;
  logic [WIDTH-1:0] w_head_b;
  logic [2:0]       w_head_f;

  assign w_not_empty = (r_count != '0);
  // No push while full, even if the head leaves at the same edge.
  assign w_in_ready  = !rst && (r_count != c_count_full);
  assign w_push      = bus.in_valid && w_in_ready;
  assign w_slot_free = (r_state == S_EMPTY) || bus.out_ready;
  assign w_issue     = w_not_empty && w_slot_free;

  assign w_head_a = w_not_empty ? r_mem_a[r_rd_ptr] : '0;
  assign w_head_b = w_not_empty ? r_mem_b[r_rd_ptr] : '0;
  assign w_head_f = w_not_empty ? r_mem_f[r_rd_ptr] : 3'b000;

  assign bus.in_ready  = w_in_ready;
  assign bus.alu_a     = w_head_a;
  assign bus.alu_b     = w_head_b;
  assign bus.alu_f     = w_head_f;
  assign bus.out_valid = (r_state == S_FULL);
  assign bus.out_y     = r_out_y;
  assign bus.out_f     = r_out_f;
  assign bus.out_zf    = r_out_zf;
  assign bus.out_of    = r_out_of;
  assign bus.out_cf    = r_out_cf;
  assign bus.count     = r_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wr_ptr] <= bus.in_a;
      r_mem_b[r_wr_ptr] <= bus.in_b;
      r_mem_f[r_wr_ptr] <= bus.in_f;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_issue})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Result slot: captured data is held after the consumer drains it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_EMPTY;
      r_out_y  <= '0;
      r_out_f  <= 3'b000;
      r_out_zf <= 1'b0;
      r_out_of <= 1'b0;
      r_out_cf <= 1'b0;
    end else begin
      if (w_issue) begin
        r_out_y  <= bus.alu_y;
        r_out_f  <= w_head_f;
        r_out_zf <= bus.alu_zf;
        r_out_of <= bus.alu_of;
        r_out_cf <= bus.alu_cf;
      end
      case (r_state)
        S_EMPTY: begin
          if (w_issue) begin
            r_state <= S_FULL;
          end
        end
        S_FULL: begin
          if (!w_issue && bus.out_ready) begin
            r_state <= S_EMPTY;
          end
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end

`ifdef ALU_ISSUE_STICKY_EN
  logic [2:0] r_sticky;

  // Clear has priority over flags arriving on the same edge.
  always_ff @(posedge clk) begin
    if (rst || bus.sticky_clr) begin
      r_sticky <= 3'b000;
    end else if (w_issue) begin
      r_sticky <= r_sticky | {bus.alu_of, bus.alu_cf, bus.alu_zf};
    end
  end

  assign bus.sticky_flags = r_sticky;
`else
  logic w_unused_sticky_clr;
  assign w_unused_sticky_clr = bus.sticky_clr;
  assign bus.sticky_flags    = 3'b000;
`endif

endmodule
`default_nettype wire

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
- Upstream feed and downstream capture stage wrapped around the combinational 4-bit ALU.
- Buffers {a, b, f} operation requests in a small FIFO and drives the head entry onto the ALU operand/function inputs.
- Captures the ALU result and flags into a single result slot with valid/ready backpressure.
- Decouples the instruction-side producer from the result consumer; throughput is one op per cycle.

Parameters:
- WIDTH, 4, operand/result width; must equal the ALU data width.
- DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  producer presents an op.
- in_ready  out  1  queue can accept an op.
- in_a  in  WIDTH  operand a.
- in_b  in  WIDTH  operand b.
- in_f  in  3  ALU function code.
- alu_a  out  WIDTH  to ALU a.
- alu_b  out  WIDTH  to ALU b.
- alu_f  out  3  to ALU f.
- alu_y  in  WIDTH  from ALU y.
- alu_zf  in  1  from ALU zf.
- alu_of  in  1  from ALU of.
- alu_cf  in  1  from ALU cf.
- out_valid  out  1  result slot full.
- out_ready  in  1  consumer accepts the result.
- out_y  out  WIDTH  captured result.
- out_f  out  3  function code of the captured op.
- out_zf  out  1  captured zf.
- out_of  out  1  captured of.
- out_cf  out  1  captured cf.
- count  out  clog2(DEPTH)+1  FIFO occupancy; excludes the result slot.
- sticky_clr  in  1  clears the sticky flags (optional feature).
- sticky_flags  out  3  {of, cf, zf} sticky OR (optional feature).

Behaviour:
- Reset (rst high at a clk edge):
  - Pointers and count cleared to 0.
  - out_valid=0; out_y, out_f, out_zf, out_of, out_cf all cleared to 0.
  - sticky_flags cleared to 0.
  - in_ready=0 while rst is high.
  - Reset mid-operation discards every queued op and the held result.
- in_ready = !rst && (count != DEPTH). There is no push bypass when full, even if a pop occurs in the same cycle.
- push = in_valid && in_ready. The entry is written at the tail on the clk edge.
- ALU drive is combinational from the FIFO head:
  - When count>0: alu_a/alu_b/alu_f = head entry.
  - When empty: alu_a=0, alu_b=0, alu_f=3'b000.
- Result slot state machine:
  - States: EMPTY (out_valid=0) and FULL (out_valid=1).
  - slot_free = EMPTY || (FULL && out_ready).
  - issue = (count>0) && slot_free.
  - On issue: pop the head, and at the same edge capture alu_y/zf/of/cf plus the head f into the out_* registers. The state becomes FULL.
  - FULL && out_ready && !issue -> EMPTY. The out_* data registers hold their last values.
  - FULL && !out_ready: the slot holds; out_* must remain stable; no pop.
- Latency: an op pushed into an empty queue with an empty slot at edge N is popped and captured at edge N+1. out_valid is high after edge N+1.
- Simultaneous push and issue: count is unchanged; the write and read pointers both advance.
- Pointers wrap modulo DEPTH. count is kept separately, so full and empty are distinguished.
- Total capacity under a stalled consumer is DEPTH+1 ops (FIFO plus slot).
- in_* values are ignored when in_valid=0 or in_ready=0.

Optional Feature:
- Macro: ALU_ISSUE_STICKY_EN.
- Defined:
  - On each issue, sticky_flags |= {alu_of, alu_cf, alu_zf}.
  - sticky_clr high clears sticky_flags to 0 at that edge.
  - If clear and issue coincide, clear wins and the new flags are dropped.
- Not defined: sticky_flags is tied to 0 and sticky_clr is ignored. The ports remain present.

Test Plan:
- Reset with out_ready=1 -> out_valid=0, count=0, in_ready=1 on the cycle after rst falls; alu_f=000, alu_a=0.
- Single op a=3, b=5, f=000 -> out_valid one edge later; out_y=8, out_of=1, out_zf=0, out_f=000.
- out_ready=0, push 6 back-to-back ops a=1..6, b=1, f=000:
  - 5 ops accepted; in_ready=0 after the 5th; count=4; out_y=2 stable.
  - Raise out_ready -> results 2,3,4,5,6 in order, one per cycle.
- Streaming with in_valid=1 and out_ready=1 every cycle (a=5, b=5, f=001) -> count stays 0 or 1, one result per cycle, out_y=0, out_zf=1.
- Assert rst for one cycle with count=3 and out_valid=1 -> next cycle count=0, out_valid=0, out_y=0; subsequent pushes start from a clean queue.
- With ALU_ISSUE_STICKY_EN: op 3+5 (of=1), then 5-5 (zf=1) -> sticky_flags=3'b101 (cf per ALU result ORed in); pulse sticky_clr -> 3'b000.
